// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the 4:1 round-robin mux arbiter
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// rtl/mux_arb_rr_pick.sv - combinational rotate-priority picker
//
// Purpose: find the first asserted request starting at ptr and wrapping
//          modulo NUM_REQ.
// Ports:
//   req  in   NUM_REQ  request vector, bit i = requester i+1
//   ptr  in   SEL_W    index that currently holds highest priority
//   any  out  1        at least one request asserted
//   idx  out  SEL_W    index of the winning requester (ptr when none)
module mux_arb_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest asserted
    // request, which has the highest priority, is written last.
    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4_by_1_rr_arbiter.sv
// rtl/mux_4_by_1_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 data mux
//
// Purpose: grants one of four requesters at a time for a burst of at most
//          MAX_BURST beats and presents the muxed data with valid/ready.
// Ports:
//   clk         in   1           clock, rising edge
//   rst_n       in   1           asynchronous active-low reset
//   req_arb     in   4           requests, bit i = requester i+1
//   data_arb_1  in   DATA_WIDTH  requester 1 data (2..4 likewise)
//   ready_out   in   1           downstream accepts a beat
//   gnt_arb     out  4           registered one-hot grant, zero when idle
//   sel_mux     out  2           registered mux select
//   valid_out   out  1           granted requester still requesting
//   data_out    out  DATA_WIDTH  selected data, zero when not valid
//   busy_arb    out  1           high while a grant is held
module mux_4_by_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4    // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_arb,
    input  logic [DATA_WIDTH-1:0] data_arb_1,
    input  logic [DATA_WIDTH-1:0] data_arb_2,
    input  logic [DATA_WIDTH-1:0] data_arb_3,
    input  logic [DATA_WIDTH-1:0] data_arb_4,
    input  logic                  ready_out,
    output logic [NUM_REQ-1:0]    gnt_arb,
    output logic [SEL_W-1:0]      sel_mux,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy_arb
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic [SEL_W-1:0]   rr_ptr, rr_ptr_n;
    logic [3:0]         beat_cnt, beat_cnt_n;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               xfer;
    logic [DATA_WIDTH-1:0] mux_data;

    mux_arb_rr_pick u_pick (
        .req (req_arb),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_arb  <= '0;
            sel_mux  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt_arb  <= gnt_n;
            sel_mux  <= sel_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    // gnt_arb is zero outside GRANT, so valid_out is implicitly low when idle.
    assign valid_out = |(gnt_arb & req_arb);
    assign xfer      = valid_out & ready_out;
    assign busy_arb  = (state == GRANT);

    always_comb begin
        state_n    = state;
        gnt_n      = gnt_arb;
        sel_n      = sel_mux;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n    = GRANT;
                    gnt_n      = NUM_REQ'(1) << pick_idx;
                    sel_n      = pick_idx;
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                // A last-beat transfer and a withdrawal on the same cycle
                // collapse into a single release.
                if ((xfer && (beat_cnt == LAST_BEAT)) || !req_arb[sel_mux]) begin
                    state_n    = IDLE;
                    gnt_n      = '0;
                    rr_ptr_n   = sel_mux + SEL_W'(1);
                    beat_cnt_n = '0;
                end else if (xfer) begin
                    beat_cnt_n = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        case (sel_mux)
            2'd0:    mux_data = data_arb_1;
            2'd1:    mux_data = data_arb_2;
            2'd2:    mux_data = data_arb_3;
            default: mux_data = data_arb_4;
        endcase
        data_out = valid_out ? mux_data : '0;
    end

endmodule

// File: tb/tb_mux_4_by_1_rr_arbiter.sv
// tb/tb_mux_4_by_1_rr_arbiter.sv - scoreboard bench for the round-robin mux arbiter
module tb_mux_4_by_1_rr_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_arb;
    logic [DW-1:0] data_arb_1, data_arb_2, data_arb_3, data_arb_4;
    logic          ready_out;
    logic [3:0]    gnt_arb;
    logic [1:0]    sel_mux;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          busy_arb;

    mux_4_by_1_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_arb    (req_arb),
        .data_arb_1 (data_arb_1),
        .data_arb_2 (data_arb_2),
        .data_arb_3 (data_arb_3),
        .data_arb_4 (data_arb_4),
        .ready_out  (ready_out),
        .gnt_arb    (gnt_arb),
        .sel_mux    (sel_mux),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .busy_arb   (busy_arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    gnt;
        logic          valid;
        logic          busy;
        logic [DW-1:0] data;
    } cyc_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } beat_t;

    cyc_t  cq[$];
    beat_t bq[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: who owns the path (-1 = nobody), beats moved so far,
    // and which requester currently has highest priority.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;

    logic [DW-1:0] d [4];
    logic [3:0]    rnd_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs and the
    // owner for the next cycle, then advance to just after the next edge.
    task automatic step(input logic [3:0] r, input logic rdy);
        cyc_t  e;
        beat_t b;
        req_arb   = r;
        ready_out = rdy;
        for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
        data_arb_1 = d[0];
        data_arb_2 = d[1];
        data_arb_3 = d[2];
        data_arb_4 = d[3];
        e = '0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_beats = 0;
                end
            end
        end else begin
            e.gnt   = 4'(1 << m_owner);
            e.busy  = 1'b1;
            e.valid = r[m_owner];
            e.data  = e.valid ? d[m_owner] : '0;
            if (e.valid && rdy) begin
                b.sel  = 2'(m_owner);
                b.data = d[m_owner];
                bq.push_back(b);
                m_beats++;
            end
            if ((e.valid && rdy && m_beats == MB) || !e.valid) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_beats = 0;
            end
        end
        cq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_gnt"},   32'(gnt_arb),   32'h0);
        chk({tag, "_sel"},   32'(sel_mux),   32'h0);
        chk({tag, "_valid"}, 32'(valid_out), 32'h0);
        chk({tag, "_data"},  32'(data_out),  32'h0);
        chk({tag, "_busy"},  32'(busy_arb),  32'h0);
    endtask

    // Monitor: compares every predicted cycle and every accepted beat.
    always @(negedge clk) begin
        cyc_t  e;
        beat_t b;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("cyc_gnt",   32'(gnt_arb),   32'(e.gnt));
            chk("cyc_valid", 32'(valid_out), 32'(e.valid));
            chk("cyc_busy",  32'(busy_arb),  32'(e.busy));
            chk("cyc_data",  32'(data_out),  32'(e.data));
            if (valid_out && ready_out) begin
                if (bq.size() == 0) begin
                    chk("unexpected_beat", 32'(1), 32'(0));
                end else begin
                    b = bq.pop_front();
                    chk("beat_sel",  32'(sel_mux),  32'(b.sel));
                    chk("beat_data", 32'(data_out), 32'(b.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_arb    = 4'hF;
        ready_out  = 1'b1;
        data_arb_1 = 8'hA1;
        data_arb_2 = 8'hB2;
        data_arb_3 = 8'hC3;
        data_arb_4 = 8'hD4;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        model_reset();

        // Single requester 3, full burst, then re-grant after the bubble.
        repeat (8) step(4'b0100, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        // Everyone requesting: rotation across all four.
        repeat (26) step(4'hF, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        // Backpressure on requester 1.
        repeat (6) step(4'b0001, 1'b0);
        repeat (6) step(4'b0001, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        // Requester 2 withdraws after two beats.
        repeat (3) step(4'b0010, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        // Requester 4 granted, reset lands mid-burst between edges.
        repeat (2) step(4'b1000, 1'b1);
        req_arb   = 4'b1000;
        ready_out = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("rst_hold");
        rst_n = 1'b1;
        model_reset();
        repeat (3) step(4'b1000, 1'b1);
        repeat (2) step(4'b0000, 1'b1);

        // Random traffic with sticky requests and random backpressure.
        rnd_req = 4'($urandom);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) rnd_req[i] = ~rnd_req[i];
            end
            step(rnd_req, ($urandom_range(3) != 0));
        end
        repeat (3) step(4'b0000, 1'b1);

        chk("cycq_drained", 32'(cq.size()), 32'(0));
        chk("beatq_drained", 32'(bq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
